// File: rtl/neopx_pkg.sv
// -----------------------------------------------------------------------------
// neopx_pkg
//   Shared types and constants for the NeoPixel frame sequencer.
//   - state_t        : frame sequencer FSM states (3-bit encoding, IDLE..LATCH)
//   - PIXEL_W        : width of one GRB pixel word
//   - DEFAULT_*      : latch gap / refresh period at 72 MHz
//   - cnt_width()    : counter width able to hold 0..n-1 (never below 1 bit)
// -----------------------------------------------------------------------------
package neopx_pkg;

    localparam int PIXEL_W                = 24;
    localparam int DEFAULT_LATCH_CYCLES   = 21600;    // 300 us at 72 MHz
    localparam int DEFAULT_REFRESH_CYCLES = 1200000;  // 60 Hz at 72 MHz

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_LATCH   = 3'd4
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neopx_pixel_bank.sv
// -----------------------------------------------------------------------------
// neopx_pixel_bank
//   Double-buffered pixel store: 2 banks x NUM_PIXELS x PIXEL_W, simple
//   dual-port. One write port (host side, back bank) and one registered read
//   port (sequencer side, front bank). The caller chooses the bank per port.
// Ports
//   axi_clk, axi_reset : clock, synchronous active-high reset (read register only)
//   wr_en/wr_bank/wr_addr/wr_data : write port; addresses >= NUM_PIXELS dropped
//   rd_en/rd_bank/rd_addr         : read request, data valid the next cycle
//   rd_data                       : registered read data, holds between reads
// -----------------------------------------------------------------------------
module neopx_pixel_bank
    import neopx_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PIXEL_W-1:0]  wr_data,
    input  logic                rd_en,
    input  logic                rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [PIXEL_W-1:0]  rd_data
);

    localparam int              DEPTH     = 2 * NUM_PIXELS;
    localparam int              IDX_W     = cnt_width(DEPTH);
    localparam logic [ADDR_W:0] PIX_COUNT = (ADDR_W + 1)'(NUM_PIXELS);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic               wr_ok;

    // Bank b occupies entries b*NUM_PIXELS .. b*NUM_PIXELS+NUM_PIXELS-1.
    function automatic logic [IDX_W-1:0] flat_idx(input logic bank,
                                                  input logic [ADDR_W-1:0] addr);
        return (bank ? IDX_W'(NUM_PIXELS) : '0) + IDX_W'(addr);
    endfunction

    assign wr_ok = wr_en && ({1'b0, wr_addr} < PIX_COUNT);

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; the array itself has no reset so it maps onto RAM.
    always_ff @(posedge axi_clk) begin
        if (wr_ok) begin
            mem[flat_idx(wr_bank, wr_addr)] <= wr_data;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[flat_idx(rd_bank, rd_addr)];
        end
    end

endmodule

// File: rtl/neopx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// neopx_frame_sequencer
//   Frame scheduler in front of the WS2812 serializer (sendPx). Streams
//   NUM_PIXELS GRB words from the front bank over an AXIS-style master, waits
//   for the serializer to drain, then holds the latch gap. Frames start on a
//   host trigger or a periodic refresh timer; host writes go to the back bank
//   and a commit swaps banks at the next frame start.
// Ports
//   axi_clk, axi_reset          : clock, synchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data : back-bank pixel write
//   i_commit                    : request bank swap at next frame start
//   i_trigger                   : request one frame
//   i_auto_en                   : enable periodic refresh
//   m_axis_data/valid/ready     : pixel stream to sendPx
//   o_busy                      : any state other than IDLE
//   o_frame_done                : one-cycle pulse on LATCH -> IDLE
//   o_commit_pending            : commit requested, swap not yet taken
//   o_debug                     : {m_axis_ready, state}
// -----------------------------------------------------------------------------
module neopx_frame_sequencer
    import neopx_pkg::*;
#(
    parameter int NUM_PIXELS     = 8,
    parameter int ADDR_W         = 3,
    parameter int LATCH_CYCLES   = DEFAULT_LATCH_CYCLES,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [PIXEL_W-1:0]  i_wr_data,
    input  logic                i_commit,
    input  logic                i_trigger,
    input  logic                i_auto_en,
    output logic [PIXEL_W-1:0]  m_axis_data,
    output logic                m_axis_valid,
    input  logic                m_axis_ready,
    output logic                o_busy,
    output logic                o_frame_done,
    output logic                o_commit_pending,
    output logic [3:0]          o_debug
);

    localparam int                LAT_W    = cnt_width(LATCH_CYCLES);
    localparam int                TMR_W    = cnt_width(REFRESH_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  idx;
    logic [LAT_W-1:0]   lat_cnt;
    logic [TMR_W-1:0]   timer;
    logic               req;
    logic               pending;
    logic               front;
    logic               rd_en;
    logic               handshake;
    logic               refresh_hit;
    logic               frame_start;

    assign handshake   = m_axis_valid && m_axis_ready;
    assign refresh_hit = i_auto_en && (timer == TMR_LAST);
    assign frame_start = (state == ST_IDLE) && req;

    assign o_busy           = (state != ST_IDLE);
    assign o_commit_pending = pending;
    assign o_debug          = {m_axis_ready, state};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx     = state;
        m_axis_valid = 1'b0;
        o_frame_done = 1'b0;
        rd_en        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                rd_en    = 1'b1;
                state_nx = ST_PRESENT;
            end
            ST_PRESENT: begin
                m_axis_valid = 1'b1;
                if (m_axis_ready) begin
                    state_nx = (idx == LAST_IDX) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // ready returning high means sendPx finished the last pixel
                if (m_axis_ready) state_nx = ST_LATCH;
            end
            ST_LATCH: begin
                if (lat_cnt == LAT_LAST) begin
                    o_frame_done = 1'b1;
                    state_nx     = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ counters and flags
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            idx     <= '0;
            lat_cnt <= '0;
            timer   <= '0;
            req     <= 1'b0;
            pending <= 1'b0;
            front   <= 1'b0;
        end else begin
            if (frame_start) begin
                idx <= '0;
            end else if (state == ST_PRESENT && handshake && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end

            if (state == ST_DRAIN) begin
                lat_cnt <= '0;
            end else if (state == ST_LATCH && lat_cnt != LAT_LAST) begin
                lat_cnt <= lat_cnt + 1'b1;
            end

            if (!i_auto_en || timer == TMR_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            // A new request in the exit cycle is kept for the following frame.
            if (i_trigger || refresh_hit) begin
                req <= 1'b1;
            end else if (frame_start) begin
                req <= 1'b0;
            end

            // The swap consumes the pending commit; a commit arriving with
            // nothing pending waits for the next frame start.
            if (frame_start && pending) begin
                pending <= 1'b0;
                front   <= ~front;
            end else if (i_commit) begin
                pending <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- pixel store
    neopx_pixel_bank #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W)
    ) u_bank (
        .axi_clk   (axi_clk),
        .axi_reset (axi_reset),
        .wr_en     (i_wr_en),
        .wr_bank   (~front),
        .wr_addr   (i_wr_addr),
        .wr_data   (i_wr_data),
        .rd_en     (rd_en),
        .rd_bank   (front),
        .rd_addr   (idx),
        .rd_data   (m_axis_data)
    );

endmodule

// File: tb/tb_neopx_frame_sequencer.sv
module tb_neopx_frame_sequencer;

    localparam int N   = 8;
    localparam int AW  = 4;
    localparam int LAT = 40;
    localparam int REF = 5000;

    logic           axi_clk = 1'b0;
    logic           axi_reset = 1'b1;
    logic           i_wr_en = 1'b0;
    logic [AW-1:0]  i_wr_addr = '0;
    logic [23:0]    i_wr_data = '0;
    logic           i_commit = 1'b0;
    logic           i_trigger = 1'b0;
    logic           i_auto_en = 1'b0;
    logic           m_axis_ready = 1'b1;
    logic [23:0]    m_axis_data;
    logic           m_axis_valid;
    logic           o_busy;
    logic           o_frame_done;
    logic           o_commit_pending;
    logic [3:0]     o_debug;

    neopx_frame_sequencer #(
        .NUM_PIXELS     (N),
        .ADDR_W         (AW),
        .LATCH_CYCLES   (LAT),
        .REFRESH_CYCLES (REF)
    ) dut (
        .axi_clk          (axi_clk),
        .axi_reset        (axi_reset),
        .i_wr_en          (i_wr_en),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_commit         (i_commit),
        .i_trigger        (i_trigger),
        .i_auto_en        (i_auto_en),
        .m_axis_data      (m_axis_data),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .o_busy           (o_busy),
        .o_frame_done     (o_frame_done),
        .o_commit_pending (o_commit_pending),
        .o_debug          (o_debug)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------ model
    // Two banks of pixels, which one is in front, and whether a swap is owed.
    logic [23:0] mbank [2][N];
    int          mfront = 0;
    bit          mpending = 0;
    logic [23:0] exp_px [N];

    // ---------------------------------------------------------- monitor
    logic [23:0] beats[$];
    int          beat_cyc[$];
    int          done_cyc[$];
    int          start_cyc[$];
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_rst = 1'b1;
    logic        prev_busy = 1'b0;
    logic [23:0] prev_data = '0;

    always @(negedge axi_clk) begin
        if (prev_valid && !prev_hs && !prev_rst) begin
            checks++;
            if (m_axis_valid !== 1'b1 || m_axis_data !== prev_data) begin
                errors++;
                $display("FAIL hold_stable @%0d: valid=%b data=%h, required valid=1 data=%h",
                         cyc, m_axis_valid, m_axis_data, prev_data);
            end
        end
        if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1) begin
            beats.push_back(m_axis_data);
            beat_cyc.push_back(cyc);
        end
        if (o_frame_done === 1'b1) done_cyc.push_back(cyc);
        if (o_busy === 1'b1 && !prev_busy) start_cyc.push_back(cyc);
        prev_valid = (m_axis_valid === 1'b1);
        prev_hs    = (m_axis_valid === 1'b1 && m_axis_ready === 1'b1);
        prev_rst   = axi_reset;
        prev_busy  = (o_busy === 1'b1);
        prev_data  = m_axis_data;
    end

    // ---------------------------------------------------------- helpers
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        beats.delete();
        beat_cyc.delete();
        done_cyc.delete();
        start_cyc.delete();
    endtask

    // One cycle of host stimulus, mirrored into the model.
    task automatic drive(input bit we, input int a, input logic [23:0] d,
                         input bit cm, input bit tr);
        i_wr_en   = we;
        i_wr_addr = AW'(a);
        i_wr_data = d;
        i_commit  = cm;
        i_trigger = tr;
        tick(1);
        i_wr_en   = 1'b0;
        i_commit  = 1'b0;
        i_trigger = 1'b0;
        if (we && a < N) mbank[mfront ^ 1][a] = d;
        if (cm) mpending = 1'b1;
        if (tr) begin
            if (mpending) begin
                mfront   = mfront ^ 1;
                mpending = 1'b0;
            end
            for (int i = 0; i < N; i++) exp_px[i] = mbank[mfront][i];
        end
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = (done_cyc.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            ok = (done_cyc.size() >= n);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = (start_cyc.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            ok = (start_cyc.size() >= n);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = (m_axis_valid === 1'b1);
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            ok = (m_axis_valid === 1'b1);
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        checks++;
        if (m_axis_valid !== 1'b0 || m_axis_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_axis: valid=%b data=%h, required 0/000000", m_axis_valid, m_axis_data);
        end
        checks++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0 || o_commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b pending=%b, required 0/0/0",
                     o_busy, o_frame_done, o_commit_pending);
        end
        checks++;
        if (o_debug !== 4'b1000) begin
            errors++;
            $display("FAIL reset_debug: got %b, required 1000", o_debug);
        end
        axi_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic_frame();
        bit ok;
        for (int i = 0; i < N; i++) drive(1, i, 24'(32'h010000 * (i + 1)), 0, 0);
        drive(0, 0, 24'h0, 1, 0);
        checks++;
        if (o_commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL t1_pending_set: got %b, required 1", o_commit_pending);
        end
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        // request is now visible in IDLE
        tick(1);
        checks++;
        if (o_busy !== 1'b1 || m_axis_valid !== 1'b0 || o_debug[2:0] !== 3'd1 || o_commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL t1_fetch: busy=%b valid=%b state=%0d pending=%b, required 1/0/1/0",
                     o_busy, m_axis_valid, o_debug[2:0], o_commit_pending);
        end
        tick(1);
        checks++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== 24'h010000) begin
            errors++;
            $display("FAIL t1_first_valid: valid=%b data=%h, required 1/010000", m_axis_valid, m_axis_data);
        end
        wait_done(1, 500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t1_timeout: frame_done not seen, required within 500 cycles");
        end
        checks++;
        if (beats.size() != N) begin
            errors++;
            $display("FAIL t1_beat_count: got %0d, required %0d", beats.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t1_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        for (int i = 1; i < N && i < beat_cyc.size(); i++) begin
            checks++;
            if (beat_cyc[i] - beat_cyc[i-1] != 2) begin
                errors++;
                $display("FAIL t1_spacing%0d: got %0d cycles, required 2", i, beat_cyc[i] - beat_cyc[i-1]);
            end
        end
        if (ok && beat_cyc.size() == N) begin
            checks++;
            if (done_cyc[0] - beat_cyc[N-1] != LAT + 1) begin
                errors++;
                $display("FAIL t1_latch_gap: got %0d cycles, required %0d",
                         done_cyc[0] - beat_cyc[N-1], LAT + 1);
            end
        end
        tick(1);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle_after: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < N; i++) drive(1, i, 24'($urandom), 0, 0);
        drive(0, 0, 24'h0, 1, 0);
        m_axis_ready = 1'b0;
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        for (int p = 0; p < N; p++) begin
            wait_valid(200, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL t2_valid_timeout: pixel %0d never valid", p);
            end
            tick($urandom_range(1, 4));
            m_axis_ready = 1'b1;
            tick(1);
            m_axis_ready = 1'b0;
            tick(50);
        end
        checks++;
        if (o_debug[2:0] !== 3'd3 || m_axis_valid !== 1'b0) begin
            errors++;
            $display("FAIL t2_drain_wait: state=%0d valid=%b, required 3/0", o_debug[2:0], m_axis_valid);
        end
        m_axis_ready = 1'b1;
        wait_done(1, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t2_timeout: frame_done not seen, required within 200 cycles");
        end
        checks++;
        if (beats.size() != N) begin
            errors++;
            $display("FAIL t2_beat_count: got %0d, required %0d", beats.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t2_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(2);
    endtask

    task automatic test_commit_timing();
        bit ok;
        // back bank written, no commit: old front goes out
        for (int i = 0; i < N; i++) drive(1, i, 24'($urandom), 0, 0);
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        tick(6);
        drive(0, 0, 24'h0, 1, 0);
        checks++;
        if (o_commit_pending !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL t3_pending_midframe: pending=%b busy=%b, required 1/1", o_commit_pending, o_busy);
        end
        wait_done(1, 500, ok);
        checks++;
        if (!ok || beats.size() != N) begin
            errors++;
            $display("FAIL t3_old_frame: done=%b beats=%0d, required 1/%0d", ok, beats.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t3_old_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(3);
        checks++;
        if (o_commit_pending !== 1'b1) begin
            errors++;
            $display("FAIL t3_pending_after: got %b, required 1", o_commit_pending);
        end
        // following frame takes the swap
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        tick(1);
        checks++;
        if (o_commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL t3_pending_clear: got %b, required 0", o_commit_pending);
        end
        wait_done(1, 500, ok);
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t3_new_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(2);
    endtask

    task automatic test_auto_refresh();
        bit ok;
        int k;
        clear_mon();
        i_auto_en = 1'b1;
        k = cyc;
        wait_starts(1, REF + 100, ok);
        checks++;
        if (!ok || start_cyc[0] - k != REF + 1) begin
            errors++;
            $display("FAIL t4_first_start: seen=%b offset=%0d, required 1/%0d",
                     ok, ok ? start_cyc[0] - k : -1, REF + 1);
        end
        tick(5);
        for (int t = 0; t < 3; t++) begin
            drive(0, 0, 24'h0, 0, 1);
            tick(3);
        end
        wait_starts(3, REF + 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t4_starts_timeout: got %0d starts, required 3", start_cyc.size());
        end else begin
            checks++;
            if (done_cyc.size() < 1 || start_cyc[1] != done_cyc[0] + 2) begin
                errors++;
                $display("FAIL t4_extra_frame: start=%0d, required %0d",
                         start_cyc[1], (done_cyc.size() > 0) ? done_cyc[0] + 2 : -1);
            end
            checks++;
            if (start_cyc[2] - start_cyc[0] != REF) begin
                errors++;
                $display("FAIL t4_period: got %0d, required %0d", start_cyc[2] - start_cyc[0], REF);
            end
            checks++;
            if (done_cyc.size() != 2) begin
                errors++;
                $display("FAIL t4_coalesce: got %0d frames before second refresh, required 2", done_cyc.size());
            end
        end
        i_auto_en = 1'b0;
        wait_done(3, 500, ok);
        tick(2);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle_end: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        m_axis_ready = 1'b0;
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        for (int p = 0; p < 3; p++) begin
            wait_valid(50, ok);
            m_axis_ready = 1'b1;
            tick(1);
            m_axis_ready = 1'b0;
        end
        wait_valid(50, ok);
        checks++;
        if (!ok || o_debug[2:0] !== 3'd2 || m_axis_data !== exp_px[3] || beats.size() != 3) begin
            errors++;
            $display("FAIL t5_at_pixel3: state=%0d data=%h beats=%0d, required 2/%h/3",
                     o_debug[2:0], m_axis_data, beats.size(), exp_px[3]);
        end
        drive(0, 0, 24'h0, 1, 0);
        axi_reset = 1'b1;
        tick(1);
        checks++;
        if (m_axis_valid !== 1'b0 || o_busy !== 1'b0 || o_debug[2:0] !== 3'd0 ||
            m_axis_data !== 24'h0 || o_commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL t5_after_reset: valid=%b busy=%b state=%0d data=%h pending=%b, required 0/0/0/000000/0",
                     m_axis_valid, o_busy, o_debug[2:0], m_axis_data, o_commit_pending);
        end
        mfront   = 0;
        mpending = 1'b0;
        axi_reset    = 1'b0;
        m_axis_ready = 1'b1;
        tick(2);
        clear_mon();
        drive(0, 0, 24'h0, 0, 1);
        wait_done(1, 500, ok);
        checks++;
        if (!ok || beats.size() != N) begin
            errors++;
            $display("FAIL t5_restart: done=%b beats=%0d, required 1/%0d", ok, beats.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t5_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(2);
    endtask

    task automatic test_addr_and_same_cycle();
        bit ok;
        for (int i = 0; i < N - 1; i++) drive(1, i, 24'($urandom), 0, 0);
        drive(1, 9,  24'hA5A5A5, 0, 0);
        drive(1, 8,  24'h5A5A5A, 0, 0);
        drive(1, 15, 24'hC3C3C3, 0, 0);
        clear_mon();
        // last write, commit and trigger all in one cycle
        drive(1, N - 1, 24'($urandom), 1, 1);
        wait_done(1, 500, ok);
        checks++;
        if (!ok || beats.size() != N) begin
            errors++;
            $display("FAIL t6_frame_a: done=%b beats=%0d, required 1/%0d", ok, beats.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t6_new_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(2);
        clear_mon();
        drive(0, 0, 24'h0, 1, 1);
        wait_done(1, 500, ok);
        for (int i = 0; i < N; i++) begin
            logic [23:0] got;
            got = (i < beats.size()) ? beats[i] : 'x;
            checks++;
            if (got !== exp_px[i]) begin
                errors++;
                $display("FAIL t6_other_pixel%0d: got %h, required %h", i, got, exp_px[i]);
            end
        end
        tick(2);
    endtask

    initial begin
        axi_reset = 1'b1;
        tick(3);
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_commit_timing();
        test_auto_refresh();
        test_reset_midframe();
        test_addr_and_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
